// File: rtl/uart_tx_framer_pkg.sv
// Shared UART transmit definitions: framer state encoding and parity-type constants.
package uart_tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Parity bit generator for the UART transmit framer, evaluated on the latched frame data.
module uart_tx_parity
    import uart_tx_framer_pkg::*;
#(
    parameter int Width = 8
)
(
    input  logic [Width-1:0] i_data,
    input  logic             i_par_typ,
    output logic             o_parity
);

    logic w_xor;

    assign w_xor    = ^i_data;
    assign o_parity = (i_par_typ == PAR_EVEN) ? w_xor : ~w_xor;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, data LSB first, optional parity, stop; one bit per clock,
// with a single-entry holding register so back-to-back frames leave no idle gap.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int Width = 8
)
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [Width-1:0] i_p_data,
    input  logic             i_data_valid,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    output logic             o_tx_out,
    output logic             o_busy,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int              CntW    = $clog2(Width);
    localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

    tx_state_e        r_state;
    tx_state_e        w_next_state;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] r_hold;
    logic [Width-1:0] w_load_data;
    logic [CntW-1:0]  r_bit_cnt;
    logic             r_par_en;
    logic             r_par_typ;
    logic             r_full;
    logic             r_overflow;
    logic             r_tx_out;
    logic             r_busy;
    logic             w_load;
    logic             w_tx;
    logic             w_parity;
    logic             w_not_idle;
    logic             w_in_stop;
    logic             w_hold_wr;
    logic             w_drop;

    uart_tx_parity #(.Width(Width)) u_parity (
        .i_data    (r_shift),
        .i_par_typ (r_par_typ),
        .o_parity  (w_parity)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A frame that ends while another byte is waiting (held or just offered) restarts at once.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = i_p_data;
        w_tx         = 1'b1;
        case (r_state)
            IDLE: begin
                if (i_data_valid) begin
                    w_next_state = START;
                    w_load       = 1'b1;
                end
            end
            START: begin
                w_tx         = 1'b0;
                w_next_state = DATA;
            end
            DATA: begin
                w_tx = r_shift[r_bit_cnt];
                if (r_bit_cnt == LastBit) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_tx         = w_parity;
                w_next_state = STOP;
            end
            STOP: begin
                if (r_full) begin
                    w_next_state = START;
                    w_load       = 1'b1;
                    w_load_data  = r_hold;
                end else if (i_data_valid) begin
                    w_next_state = START;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_not_idle = (r_state != IDLE);
    assign w_in_stop  = (r_state == STOP);
    assign w_hold_wr  = i_data_valid && w_not_idle &&
                        ((!r_full && !w_in_stop) || (r_full && w_in_stop));
    assign w_drop     = i_data_valid && r_full && !w_in_stop;

    // Line outputs are registered from the current state, so each bit follows its state by one edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_hold     <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx_out   <= w_tx;
            r_busy     <= w_not_idle;
            r_overflow <= w_drop;
            if (w_load) begin
                r_shift   <= w_load_data;
                r_par_en  <= i_par_en;
                r_par_typ <= i_par_typ;
            end
            if (r_state == DATA) begin
                r_bit_cnt <= (r_bit_cnt == LastBit) ? '0 : r_bit_cnt + CntW'(1);
            end
            if (w_hold_wr) begin
                r_hold <= i_p_data;
                r_full <= 1'b1;
            end else if (w_in_stop && r_full) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_tx_out   = r_tx_out;
    assign o_busy     = r_busy;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;

endmodule
